gf_mw_adder_ctrl: RTL and testbench
===================================

// Module: gf_mw_adder_ctrl
// PURPOSE
//   Adds NUM_WORDS*DATA_WIDTH-bit operands by cycling one gf_rca_adder (DATA_WIDTH wide) word by word, LSW first.
//   The adder has no carry-in, so a carried-in word takes a second INC pass (sum + 1).
//   Mode (integer / GF(2) carry-less) is selected per operation.
//   Valid/ready in and out; sits between operand staging and result consumers.
// PARAMETERS
//   DATA_WIDTH  32  width of the shared gf_rca_adder instance, bits per word
//   NUM_WORDS   4   words per operand (>=1); operand width W = DATA_WIDTH*NUM_WORDS
// PORTS
//   clk           in   1  single clock, rising edge
//   rst           in   1  synchronous, active-high reset
//   start_valid   in   1  operation request
//   start_ready   out  1  1 only in IDLE; accept = start_valid & start_ready
//   gf_option_in  in   1  1 = GF(2) add (XOR, no carry), 0 = integer add; sampled at accept
//   a_in          in   W  operand A, sampled at accept
//   b_in          in   W  operand B, sampled at accept
//   result_valid  out  1  sum_out/co_out valid; held until result_ready
//   result_ready  in   1  consumer accepts result when high with result_valid
//   sum_out       out  W  registered result
//   co_out        out  1  carry out of MSW; always 0 in GF mode
//   busy          out  1  1 in ADD/INC/DONE
// BEHAVIOUR
//   Reset: state IDLE, start_ready=1, result_valid=0, busy=0, sum_out=0, co_out=0, idx=0, carry=0.
//   Inputs are ignored outside the accept cycle.
//   FSM: IDLE -> ADD -> {INC} -> ADD ... -> DONE -> IDLE.
//   IDLE: on accept, latch a, b and mode; clear sum_out, co_out, idx and carry; go to ADD.
//   ADD (word idx): adder a = A[idx], b = B[idx], gf_option = latched mode.
//     GF mode: sum_out[idx] <= sum; carry stays 0.
//     Integer mode, carry=0: sum_out[idx] <= sum; carry <= co.
//     Integer mode, carry=1: tmp <= sum; co1 <= co; go to INC (idx held).
//   INC: adder a = tmp, b = 1 (zero-extended). sum_out[idx] <= sum; carry <= co1 | co.
//     co1 and co are never both 1.
//   Word advance after ADD (no INC) or INC:
//     idx == NUM_WORDS-1: co_out <= final carry (0 in GF mode); go to DONE.
//     Otherwise: idx++ and go to ADD.
//   DONE: result_valid=1. sum_out and co_out are stable while result_ready=0.
//     On result_valid & result_ready, go to IDLE; start_ready returns 1 the next cycle.
//     A new start can never overlap a pending result.
//   Latency: accept in cycle 0 -> result_valid in cycle 1 + NUM_WORDS + n_inc.
//     n_inc = number of words entered with carry=1, from 0 to NUM_WORDS-1; always 0 in GF mode.
//   Arithmetic: integer result = (A + B) mod 2^W with co_out = bit W; GF result = A ^ B.
//   Reset mid-operation (any state): return to IDLE with reset values next cycle.
//     The partial result is discarded and no result_valid is produced.
//   NUM_WORDS=1: single ADD; INC is never entered.
// TESTING (DATA_WIDTH=8, NUM_WORDS=4)
//   Int, A=0x000000FF, B=0x00000001
//     -> sum_out=0x00000100, co_out=0; one INC; result_valid in cycle 6.
//   Int, A=0xFFFFFFFF, B=0x00000001
//     -> sum_out=0x00000000, co_out=1; INC on words 1-3; result_valid in cycle 8.
//   GF, A=0xFFFFFFFF, B=0x00000001
//     -> sum_out=0xFFFFFFFE, co_out=0; no INC; result_valid in cycle 5.
//   Backpressure: result_ready=0 for 3 cycles in DONE
//     -> outputs held, start_ready=0, start_valid ignored; IDLE after handshake.
//   rst=1 during INC of test 2
//     -> next cycle IDLE, start_ready=1, result_valid=0, sum_out=0, co_out=0.
//   Back-to-back starts with start_valid=1 and result_ready=1
//     -> second accept exactly 1 cycle after the first result handshake; both results correct.

Source files
------------

// File: rtl/gf_mw_adder_ctrl_if.sv
// gf_mw_adder_ctrl_if: start/result handshake bundle for the
// multi-word integer / GF(2) adder controller.
interface gf_mw_adder_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4
);
  localparam int W = DATA_WIDTH * NUM_WORDS;

  logic         start_valid;
  logic         start_ready;
  logic         gf_option_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum_out;
  logic         co_out;
  logic         busy;

  modport master (
    output start_valid, gf_option_in, a_in, b_in,
    output result_ready,
    input  start_ready, result_valid, sum_out,
    input  co_out, busy
  );

  modport slave (
    input  start_valid, gf_option_in, a_in, b_in,
    input  result_ready,
    output start_ready, result_valid, sum_out,
    output co_out, busy
  );
endinterface

// File: rtl/gf_mw_adder_ctrl.sv
// gf_mw_adder_ctrl: wide integer / GF(2) add on one shared
// word adder, LSW first, with an INC pass for carried-in words.
module gf_mw_adder_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4
) (
  input logic               clk,
  input logic               rst,
  gf_mw_adder_ctrl_if.slave bus
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] words_t;
  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

  state_t          state_q, state_d;
  words_t          a_q, a_d;
  words_t          b_q, b_d;
  words_t          sum_q, sum_d;
  logic            gf_q, gf_d;
  logic            co_q, co_d;
  logic            carry_q, carry_d;
  logic            co1_q, co1_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] tmp_q, tmp_d;

  logic [DATA_WIDTH-1:0] add_a, add_b, add_s;
  logic                  add_gf, add_co;
  logic                  carry_nx, adv, last;

  assign last = (idx_q == IW'(NUM_WORDS - 1));

  // INC reuses the adder as tmp + 1 in integer mode
  always_comb begin
    add_a  = a_q[idx_q];
    add_b  = b_q[idx_q];
    add_gf = gf_q;
    if (state_q == INC) begin
      add_a  = tmp_q;
      add_b  = DATA_WIDTH'(1);
      add_gf = 1'b0;
    end
  end

  always_comb begin
    {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b};
    if (add_gf) begin
      add_s  = add_a ^ add_b;
      add_co = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    gf_d     = gf_q;
    co_d     = co_q;
    carry_d  = carry_q;
    co1_d    = co1_q;
    idx_d    = idx_q;
    tmp_d    = tmp_q;
    carry_nx = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          gf_d    = bus.gf_option_in;
          sum_d   = '0;
          co_d    = 1'b0;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (!gf_q && carry_q) begin
          tmp_d   = add_s;
          co1_d   = add_co;
          state_d = INC;
        end else begin
          sum_d[idx_q] = add_s;
          carry_nx     = add_co;
          adv          = 1'b1;
        end
      end
      INC: begin
        sum_d[idx_q] = add_s;
        carry_nx     = co1_q | add_co;
        adv          = 1'b1;
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      carry_d = carry_nx;
      if (last) begin
        co_d    = carry_nx;
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ADD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      gf_q    <= 1'b0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      co1_q   <= 1'b0;
      idx_q   <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      gf_q    <= gf_d;
      co_q    <= co_d;
      carry_q <= carry_d;
      co1_q   <= co1_d;
      idx_q   <= idx_d;
      tmp_q   <= tmp_d;
    end
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.sum_out      = sum_q;
  assign bus.co_out       = co_q;
endmodule

// File: tb/tb_gf_mw_adder_ctrl.sv
// tb_gf_mw_adder_ctrl: scoreboard bench for the multi-word
// adder controller, 8-bit words x 4.
module tb_gf_mw_adder_ctrl;
  localparam int DW = 8;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_mw_adder_ctrl_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus();

  gf_mw_adder_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   hs_cyc = -1;
  int   first_cyc = 0;
  int   n_res = 0;
  int   n_exp = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // latency counts words that see a carry from the words below
  function automatic exp_t model(input bit gf,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input int acc);
    exp_t       e;
    logic [W:0] s, m, lo;
    int         ninc;
    ninc = 0;
    if (gf) begin
      e.sum = a ^ b;
      e.co  = 1'b0;
    end else begin
      s     = {1'b0, a} + {1'b0, b};
      e.sum = s[W-1:0];
      e.co  = s[W];
      for (int i = 1; i < NW; i++) begin
        m  = ((W+1)'(1) << (i * DW)) - (W+1)'(1);
        lo = ({1'b0, a} & m) + ({1'b0, b} & m);
        if (lo[i*DW]) ninc++;
      end
    end
    e.lat = 1 + NW + ninc;
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (!seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (q.size() == 0) begin
        chk("spurious_valid", 64'(q.size()), 64'd1);
      end else begin
        chk("sum_out", bus.sum_out, q[0].sum);
        chk("co_out", bus.co_out, q[0].co);
        chk("start_ready_done", bus.start_ready, 1'b0);
        chk("busy_done", bus.busy, 1'b1);
        if (bus.result_ready) begin
          chk("latency", 64'(first_cyc - q[0].acc), 64'(q[0].lat));
          void'(q.pop_front());
          hs_cyc = cyc;
          n_res++;
        end
      end
      if (bus.result_ready) seen = 1'b0;
    end
  end

  task automatic start_op(input bit gf,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input bit keep,
                          output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    bus.start_valid  = 1'b1;
    bus.gf_option_in = gf;
    bus.a_in         = a;
    bus.b_in         = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.start_ready) ok = 1'b1;
    end
    chk("accept_timeout", ok, 1'b1);
    if (ok) begin
      acc = cyc;
      q.push_back(model(gf, a, b, cyc));
      n_exp++;
    end
    @(posedge clk);
    #1;
    if (!keep) bus.start_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && bus.start_ready) ok = 1'b1;
    end
    chk("done_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           acc, acc2, k;
    bit           ok, gf;
    logic [W-1:0] a, b;
    bus.start_valid  = 1'b0;
    bus.gf_option_in = 1'b0;
    bus.a_in         = '0;
    bus.b_in         = '0;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", bus.start_ready, 1'b1);
    chk("rst_result_valid", bus.result_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sum", bus.sum_out, '0);
    chk("rst_co", bus.co_out, 1'b0);
    @(posedge clk);
    #1;

    start_op(1'b0, 32'h000000FF, 32'h00000001, 1'b0, acc);
    wait_done();
    start_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, acc);
    wait_done();
    start_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, acc);
    wait_done();

    // backpressure: junk starts while DONE must be ignored
    bus.result_ready = 1'b0;
    start_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, acc);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.result_valid) ok = 1'b1;
    end
    chk("valid_timeout", ok, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
      bus.start_valid  = 1'b1;
      bus.gf_option_in = 1'b1;
      bus.a_in         = $urandom;
      bus.b_in         = $urandom;
      @(negedge clk);
      chk("bp_valid_held", bus.result_valid, 1'b1);
      chk("bp_start_ready", bus.start_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", bus.start_ready, 1'b1);
    chk("bp_idle_busy", bus.busy, 1'b0);
    chk("bp_queue", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;

    // reset during the INC pass of word 1
    start_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_exp -= q.size();
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_start_ready", bus.start_ready, 1'b1);
    chk("mid_rst_result_valid", bus.result_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_sum", bus.sum_out, '0);
    chk("mid_rst_co", bus.co_out, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;

    start_op(1'b0, 32'h00FF00FF, 32'h00010001, 1'b1, acc);
    start_op(1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, acc2);
    chk("b2b_gap", 64'(acc2 - hs_cyc), 64'd1);
    wait_done();

    for (int n = 0; n < 20; n++) begin
      gf = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      k  = int'($urandom_range(0, 3));
      if (k == 0) b = ~a;
      if (k == 1) b = ~a + 1'b1;
      start_op(gf, a, b, 1'b0, acc);
      wait_done();
    end

    chk("results_seen", 64'(n_res), 64'(n_exp));
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
